// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester side and FIFO write side of the operand FIFO write arbiter.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_wr;
   logic [DATA_WIDTH-1:0]         fifo_din;
   logic                          rd_done;
   logic [CW-1:0]                 credits;
   logic                          busy;
   logic                          err;
   modport master (output req, req_data, rd_done, input gnt, fifo_wr, fifo_din, credits, busy, err);
   modport slave (input req, req_data, rd_done, output gnt, fifo_wr, fifo_din, credits, busy, err);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of the operand FIFO write port, one strobe per grant
// followed by a low gap, with credit tracking so a full FIFO is never written.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_CYCLES = 1
) (
   input logic              clock,
   input logic              reset,
   fifo_wr_arbiter_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int LW = $clog2(NUM_REQ);
   localparam int HW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
   state_t                state_q, state_d;
   logic [LW-1:0]         last_q, last_d, win;
   logic [HW-1:0]         hold_q, hold_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic                  fifo_wr_q, fifo_wr_d;
   logic [DATA_WIDTH-1:0] fifo_din_q, fifo_din_d;
   logic [CW-1:0]         credits_q, credits_d;
   logic                  err_q, err_d;
   logic                  found, grant, full;
   // Scan starts just after the last winner so every requester is reached within NUM_REQ grants.
   always_comb begin
      win   = last_q;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && bus.req[(int'(last_q) + k) % NUM_REQ]) begin
            win   = LW'((int'(last_q) + k) % NUM_REQ);
            found = 1'b1;
         end
      end
   end
   always_comb begin
      full       = credits_q == CW'(FIFO_DEPTH);
      grant      = (state_q == IDLE) && found && (credits_q != '0);
      gnt_d      = grant ? NUM_REQ'(1) << win : '0;
      fifo_wr_d  = grant;
      fifo_din_d = grant ? bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH] : fifo_din_q;
      last_d     = grant ? win : last_q;
      state_d    = (state_q == IDLE)  ? (grant ? WRITE : IDLE) :
                   (state_q == WRITE) ? HOLD :
                   (hold_q == '0)     ? IDLE : HOLD;
      hold_d     = (state_q == WRITE) ? HW'(GAP_CYCLES - 1) :
                   (state_q == HOLD && hold_q != '0) ? hold_q - 1'b1 : hold_q;
      // A pop on a grant edge cancels the grant's debit; a pop with no entry outstanding is an error.
      credits_d  = (grant && !bus.rd_done) ? credits_q - 1'b1 :
                   (!grant && bus.rd_done && !full) ? credits_q + 1'b1 : credits_q;
      err_d      = err_q | (bus.rd_done & ~grant & full);
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         last_q     <= LW'(NUM_REQ - 1);
         hold_q     <= '0;
         gnt_q      <= '0;
         fifo_wr_q  <= 1'b0;
         fifo_din_q <= '0;
         credits_q  <= CW'(FIFO_DEPTH);
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_q     <= hold_d;
         gnt_q      <= gnt_d;
         fifo_wr_q  <= fifo_wr_d;
         fifo_din_q <= fifo_din_d;
         credits_q  <= credits_d;
         err_q      <= err_d;
      end
   end
   assign bus.gnt      = gnt_q;
   assign bus.fifo_wr  = fifo_wr_q;
   assign bus.fifo_din = fifo_din_q;
   assign bus.credits  = credits_q;
   assign bus.err      = err_q;
   assign bus.busy     = state_q != IDLE;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random stimulus; a queue-based reference model predicts
// grants, credits and errors, and a negedge monitor compares the DUT against it.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int D  = 8;
   localparam int G  = 1;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;
   fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus();
   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .GAP_CYCLES(G)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );
   typedef struct {int idx; logic [DW-1:0] data;} exp_t;
   exp_t          sb[$];
   exp_t          e;
   int            n_chk = 0;
   int            n_fail = 0;
   int            tcyc = 0;
   int            m_credits, m_last, m_next_ok, cyc, mw;
   bit            m_err, m_busy, m_wr, mg;
   logic [DW-1:0] m_din;
   logic [N-1:0]  exp_gnt;
   always @(posedge clock) tcyc++;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference model: a grant may happen once the previous one is 2+G cycles old, goes to the
   // first requester after the last winner, and needs a free FIFO entry.
   initial forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
         m_credits = D; m_last = N - 1; m_next_ok = 0; cyc = 0;
         m_err = 0; m_busy = 0; m_wr = 0; m_din = '0;
         sb.delete();
      end else begin
         mg = cyc >= m_next_ok && bus.req != '0 && m_credits > 0;
         if (mg) begin
            mw = -1;
            for (int k = 1; k <= N; k++)
               if (mw < 0 && bus.req[(m_last + k) % N]) mw = (m_last + k) % N;
            sb.push_back('{mw, bus.req_data[mw*DW +: DW]});
            m_din = bus.req_data[mw*DW +: DW];
            m_last = mw;
            m_next_ok = cyc + 2 + G;
         end
         if (mg && !bus.rd_done) m_credits--;
         else if (!mg && bus.rd_done) begin
            if (m_credits == D) m_err = 1;
            else m_credits++;
         end
         m_wr = mg;
         m_busy = cyc < m_next_ok - 1;
         cyc++;
      end
   end
   initial forever begin
      @(negedge clock);
      if (reset) begin
         if (bus.gnt != '0) begin
            if (sb.size() == 0) chk("unexpected_gnt", bus.gnt, 0);
            else begin
               e = sb.pop_front();
               exp_gnt = N'(1) << e.idx;
               chk("gnt_onehot", bus.gnt, exp_gnt);
               chk("grant_data", bus.fifo_din, e.data);
            end
         end else if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("missing_gnt", 0, 1);
         end
         chk("fifo_wr", bus.fifo_wr, m_wr);
         chk("fifo_din_hold", bus.fifo_din, m_din);
         chk("credits", bus.credits, m_credits);
         chk("err", bus.err, m_err);
         chk("busy", bus.busy, m_busy);
      end
   end
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0; bus.req = '0; bus.rd_done = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask
   task automatic wait_gnt(input int max, output int w);
      w = -1;
      for (int k = 0; k < max && w < 0; k++) begin
         tick();
         for (int i = 0; i < N; i++) if (bus.gnt[i]) w = i;
      end
      if (w < 0) chk("gnt_timeout", 0, 1);
   endtask
   task automatic drive_random(input int p_req, input int p_rd);
      for (int i = 0; i < N; i++) begin
         if (bus.gnt[i]) begin
            if ($urandom_range(1) == 0) bus.req[i] = 1'b0;
            else bus.req_data[i*DW +: DW] = $urandom;
         end else if (!bus.req[i] && $urandom_range(99) < p_req) begin
            bus.req[i] = 1'b1;
            bus.req_data[i*DW +: DW] = $urandom;
         end else if (bus.req[i] && $urandom_range(99) < 2) bus.req[i] = 1'b0;
      end
      bus.rd_done = (m_credits < D) && ($urandom_range(99) < p_rd);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int w, prev, cnt;
      bus.req = '0; bus.req_data = '0; bus.rd_done = 1'b0;
      do_reset();
      repeat (5) tick();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_fifo_wr", bus.fifo_wr, 0);
      chk("rst_credits", bus.credits, 8);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      bus.req_data[0 +: DW] = 32'hA5A5_0001;
      bus.req = 4'b0001;
      wait_gnt(10, w);
      chk("t2_gnt", bus.gnt, 4'b0001);
      chk("t2_wr", bus.fifo_wr, 1);
      chk("t2_din", bus.fifo_din, 32'hA5A5_0001);
      bus.req = '0;
      tick();
      chk("t2_wr_low", bus.fifo_wr, 0);
      chk("t2_credits", bus.credits, 7);
      do_reset();
      for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 32'hB000_0000 + i;
      bus.req = 4'b1111;
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         wait_gnt(10, w);
         chk("rr_order", w, k % N);
         if (k > 0) chk("rr_spacing", tcyc - prev, 3);
         prev = tcyc;
         if (w >= 0) begin
            chk("rr_din", bus.fifo_din, 32'hB000_0000 + w);
            bus.req[w] = 1'b0;
            tick();
            bus.req[w] = 1'b1;
         end
      end
      bus.req = '0;
      do_reset();
      bus.req_data[2*DW +: DW] = $urandom;
      bus.req = 4'b0100;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.gnt[2]) begin cnt++; bus.req_data[2*DW +: DW] = $urandom; end
      end
      chk("t4_grants", cnt, 8);
      chk("t4_credits0", bus.credits, 0);
      chk("t4_stall_busy", bus.busy, 0);
      bus.rd_done = 1'b1;
      tick();
      bus.rd_done = 1'b0;
      chk("t4_credit1", bus.credits, 1);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.gnt[2]) begin cnt++; bus.req_data[2*DW +: DW] = $urandom; end
      end
      chk("t4_one_more", cnt, 1);
      chk("t4_credits_end", bus.credits, 0);
      bus.req = '0;
      bus.rd_done = 1'b1;
      repeat (3) tick();
      bus.rd_done = 1'b0;
      chk("t5_credits3", bus.credits, 3);
      bus.req_data[2*DW +: DW] = 32'hC0DE_0005;
      bus.req = 4'b0100;
      bus.rd_done = 1'b1;
      tick();
      bus.req = '0;
      bus.rd_done = 1'b0;
      chk("t5_gnt", bus.gnt, 4'b0100);
      chk("t5_same_edge", bus.credits, 3);
      repeat (3) tick();
      bus.rd_done = 1'b1;
      repeat (5) tick();
      chk("t5_full", bus.credits, 8);
      chk("t5_no_err_yet", bus.err, 0);
      tick();
      bus.rd_done = 1'b0;
      chk("t5_sat", bus.credits, 8);
      chk("t5_err", bus.err, 1);
      repeat (5) tick();
      chk("t5_err_sticky", bus.err, 1);
      do_reset();
      bus.req_data[0 +: DW] = 32'hD00D_0000;
      bus.req = 4'b0001;
      wait_gnt(10, w);
      bus.req = '0;
      chk("t6_write_wr", bus.fifo_wr, 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_wr", bus.fifo_wr, 0);
      chk("t6_async_gnt", bus.gnt, 0);
      do_reset();
      bus.req = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(10, w);
         bus.req_data[2*DW +: DW] = $urandom;
      end
      bus.req = '0;
      chk("t6_credits5", bus.credits, 5);
      tick();
      chk("t6_in_hold", bus.busy, 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_hold_wr", bus.fifo_wr, 0);
      chk("t6_hold_credits", bus.credits, 8);
      chk("t6_hold_busy", bus.busy, 0);
      bus.req_data[0 +: DW] = 32'hE000_0000;
      bus.req_data[2*DW +: DW] = 32'hE000_0002;
      bus.req = 4'b0101;
      @(negedge clock);
      reset = 1'b1;
      wait_gnt(10, w);
      chk("t6_first", w, 0);
      chk("t6_first_din", bus.fifo_din, 32'hE000_0000);
      bus.req = '0;
      repeat (4) tick();
      for (int s = 0; s < 3000; s++) begin
         tick();
         drive_random(20 + s % 60, ((s / 500) % 2) ? 15 : 60);
      end
      bus.req = '0;
      bus.rd_done = 1'b0;
      repeat (10) tick();
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the operand FIFO between NUM_REQ requesters (e.g. keypad entry, ALU result writeback). The FIFO detects writes on the rising edge of its write input, so this block issues every write as a strobe: one cycle high, then at least GAP_CYCLES low. It tracks FIFO occupancy with a credit counter, so it never writes into a full FIFO. The counter is replenished by a pop pulse from the read side.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 32, FIFO word width
FIFO_DEPTH, 8, usable FIFO entries; this is also the credit count at reset
GAP_CYCLES, 1, minimum low cycles on fifo_wr after each strobe (>=1)
CW, $clog2(FIFO_DEPTH+1), width of the credit counter (derived; not overridden)

Ports:
clock  in  1  single system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester; held until that requester's gnt
req_data  in  NUM_REQ*DATA_WIDTH  word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_REQ  registered one-hot pulse: the requester's word was accepted
fifo_wr  out  1  registered write strobe to the FIFO
fifo_din  out  DATA_WIDTH  registered write data to the FIFO
rd_done  in  1  one-cycle pulse per word popped from the FIFO
credits  out  CW  free FIFO entries as tracked by this block
busy  out  1  high whenever the FSM is not in IDLE
err  out  1  sticky: rd_done arrived while credits==FIFO_DEPTH

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, gnt=0, fifo_wr=0, fifo_din=0, credits=FIFO_DEPTH, err=0.
  - last=NUM_REQ-1, so requester 0 has first priority.
  - Deassertion is sampled at the next rising edge.
- FSM states are IDLE, WRITE and HOLD.
- IDLE: a requester is eligible when (req!=0) and (credits!=0). When eligible:
  - Winner = first i with req[i]=1, scanning i=(last+1) mod NUM_REQ upward with wrap-around.
  - At that edge: gnt[winner]<=1, fifo_din<=req_data[winner], fifo_wr<=1, last<=winner, state<=WRITE.
  - Otherwise all outputs hold and gnt=0.
- WRITE (exactly 1 cycle): gnt<=0, fifo_wr<=0, hold counter<=GAP_CYCLES-1, state<=HOLD.
- HOLD: fifo_wr stays 0. Leave for IDLE when the hold counter reaches 0; otherwise decrement it.
- fifo_din is stable from the WRITE cycle to the end of HOLD. It only changes on the next grant.
- Throughput: one write every 2+GAP_CYCLES cycles (3 cycles at default).
- Grant-to-strobe latency: gnt and fifo_wr rise on the same edge, one edge after req is sampled in IDLE.
- Requester handshake: keep req and the data stable until gnt is seen high. Drop req or present the next word on the following edge. A req dropped before grant is simply not served.
- Credits:
  - Decrement by 1 on the edge that issues a grant.
  - Increment by 1 on rd_done.
  - Grant and rd_done on the same edge: credits unchanged.
  - rd_done with credits==FIFO_DEPTH and no grant on that edge: credits unchanged, err<=1 (cleared only by reset).
  - credits==0 blocks grants. Requests wait in IDLE, and busy stays 0.
- rd_done is accepted in every state.
- Reset asserted mid-WRITE/HOLD: fifo_wr drops immediately (asynchronous). Credits return to FIFO_DEPTH. The FIFO is reset on the same net.
- busy = (state!=IDLE), decoded from state.

Test Plan:
1. Reset, then idle for 5 cycles -> gnt=0, fifo_wr=0, credits=8, busy=0, err=0.
2. req=4'b0001 with data0=32'hA5A5_0001 -> gnt=4'b0001 and fifo_wr=1 on the same cycle, fifo_din=32'hA5A5_0001, then fifo_wr low for 1 cycle, credits=7.
3. req=4'b1111 held, each requester dropping req after its gnt and re-raising it -> grant order 0,1,2,3,0,1. gnt pulses are 3 cycles apart. Each fifo_din matches the granted requester.
4. Continuous req=4'b0100, no rd_done -> exactly 8 grants, then credits=0 and req stalls. One rd_done pulse -> credits=1, exactly one more grant, credits=0.
5. rd_done on the same edge as a grant with credits=3 -> credits stays 3. rd_done with credits=8 and no grant -> credits stays 8, err=1, and err stays 1 until reset.
6. Assert reset during HOLD with credits=5 and last=2 -> fifo_wr=0 immediately. After release: credits=8, and req=4'b0101 grants requester 0 first.
